// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the DMA/loader port and data_memory.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              core_rd_en;
   logic              core_wd_en;
   logic [2:0]        core_op_sel;
   logic [ADDR_W-1:0] core_addr;
   logic [31:0]       core_data_w;
   logic [31:0]       core_data_r;
   logic              stallM;

   logic              dma_req_valid;
   logic              dma_req_ready;
   logic              dma_req_we;
   logic [ADDR_W-1:0] dma_req_addr;
   logic [31:0]       dma_req_wdata;
   logic              dma_rsp_valid;
   logic [31:0]       dma_rsp_rdata;

   logic              mem_w_en;
   logic              mem_r_en;
   logic [2:0]        mem_op_sel;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_data_w;
   logic [31:0]       mem_data_r;

   modport slave (
      input  core_rd_en, core_wd_en, core_op_sel, core_addr, core_data_w,
      output core_data_r, stallM,
      input  dma_req_valid, dma_req_we, dma_req_addr, dma_req_wdata,
      output dma_req_ready, dma_rsp_valid, dma_rsp_rdata,
      output mem_w_en, mem_r_en, mem_op_sel, mem_addr, mem_data_w,
      input  mem_data_r
   );

   modport master (
      output core_rd_en, core_wd_en, core_op_sel, core_addr, core_data_w,
      input  core_data_r, stallM,
      output dma_req_valid, dma_req_we, dma_req_addr, dma_req_wdata,
      input  dma_req_ready, dma_rsp_valid, dma_rsp_rdata,
      input  mem_w_en, mem_r_en, mem_op_sel, mem_addr, mem_data_w,
      output mem_data_r
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core has priority, a starving DMA request forces a
// bounded burst window (core stalled), followed by one cooldown cycle.
// Optional statistics counters are enabled with the DMEM_ARB_STATS_EN macro.
module dmem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int BURST_MAX    = 4,
   parameter int ADDR_W       = 32
) (
   input  logic            clk,
   input  logic            rst,
   dmem_arbiter_if.slave   bus
`ifdef DMEM_ARB_STATS_EN
   ,
   input  logic            stats_clr,
   output logic [31:0]     stall_cycles,
   output logic [31:0]     dma_beats
`endif
);

   typedef enum logic [1:0] {IDLE, DMA_OWN, COOL} state_t;

   state_t      state;
   logic [3:0]  starve_cnt;
   logic [4:0]  beat_cnt;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;

   logic        core_acc;
   logic        ready;
   logic        stall;
   logic        beat;
   logic        core_grant;
   logic        unused_addr_bits;

   // Grant decode: ready/stall come only from state and core_acc, never from stall itself
   always_comb begin
      core_acc = bus.core_rd_en | bus.core_wd_en;
      ready    = 1'b0;
      stall    = 1'b0;
      if (!rst) begin
         case (state)
            IDLE:    ready = ~core_acc;
            DMA_OWN: begin
               ready = 1'b1;
               stall = core_acc;
            end
            default: ready = 1'b0;
         endcase
      end
      beat       = bus.dma_req_valid & ready;
      core_grant = ~rst & core_acc & ~stall;
   end

   // Memory port mux; a DMA beat and a core grant are mutually exclusive by construction
   always_comb begin
      bus.mem_w_en   = 1'b0;
      bus.mem_r_en   = 1'b0;
      bus.mem_op_sel = 3'b000;
      bus.mem_addr   = '0;
      bus.mem_data_w = 32'h0;
      if (beat) begin
         bus.mem_w_en   = bus.dma_req_we;
         bus.mem_r_en   = ~bus.dma_req_we;
         bus.mem_op_sel = 3'b010;
         bus.mem_addr   = {bus.dma_req_addr[ADDR_W-1:2], 2'b00};
         bus.mem_data_w = bus.dma_req_wdata;
      end else if (core_grant) begin
         bus.mem_w_en   = bus.core_wd_en;
         bus.mem_r_en   = bus.core_rd_en;
         bus.mem_op_sel = bus.core_op_sel;
         bus.mem_addr   = bus.core_addr;
         bus.mem_data_w = bus.core_data_w;
      end
   end

   assign unused_addr_bits  = &{1'b0, bus.dma_req_addr[1:0]};
   assign bus.core_data_r   = bus.mem_data_r;
   assign bus.stallM        = stall;
   assign bus.dma_req_ready = ready;
   assign bus.dma_rsp_valid = rsp_valid;
   assign bus.dma_rsp_rdata = rsp_rdata;

   // Ownership FSM with starvation/burst counters and the registered DMA response
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         starve_cnt <= 4'd0;
         beat_cnt   <= 5'd0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= 32'h0;
      end else begin
         rsp_valid <= beat;
         if (beat) begin
            rsp_rdata <= bus.dma_req_we ? 32'h0 : bus.mem_data_r;
         end
         case (state)
            IDLE: begin
               if (!bus.dma_req_valid || beat) begin
                  starve_cnt <= 4'd0;
               end else begin
                  if (starve_cnt != 4'(STARVE_LIMIT)) begin
                     starve_cnt <= starve_cnt + 4'd1;
                  end
                  if (starve_cnt == 4'(STARVE_LIMIT - 1)) begin
                     state    <= DMA_OWN;
                     beat_cnt <= 5'd0;
                  end
               end
            end
            DMA_OWN: begin
               starve_cnt <= 4'd0;
               if (!bus.dma_req_valid) begin
                  state <= COOL;
               end else begin
                  beat_cnt <= beat_cnt + 5'd1;
                  if (beat_cnt == 5'(BURST_MAX - 1)) begin
                     state <= COOL;
                  end
               end
            end
            COOL:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DMEM_ARB_STATS_EN
   // Stall-cycle and accepted-beat counters; a clear wins over a coincident event
   always_ff @(posedge clk) begin
      if (rst || stats_clr) begin
         stall_cycles <= 32'h0;
         dma_beats    <= 32'h0;
      end else begin
         if (stall) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (beat) begin
            dma_beats <= dma_beats + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a behavioural ownership/memory model.
module tb_dmem_arbiter;

   localparam int STARVE_LIMIT = 4;
   localparam int BURST_MAX    = 4;
   localparam int ADDR_W       = 32;

   logic clk = 1'b0;
   logic rst;
   logic memInit;

   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef DMEM_ARB_STATS_EN
   logic        statsClr;
   logic [31:0] stallCycles;
   logic [31:0] dmaBeats;
`endif

   dmem_arbiter #(
      .STARVE_LIMIT(STARVE_LIMIT),
      .BURST_MAX(BURST_MAX),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef DMEM_ARB_STATS_EN
      ,
      .stats_clr(statsClr),
      .stall_cycles(stallCycles),
      .dma_beats(dmaBeats)
`endif
   );

   // Simple word-wide data memory with combinational read
   logic [31:0] mem [64];

   always @(posedge clk) begin
      if (memInit) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      end else if (bus.mem_w_en) begin
         mem[bus.mem_addr[7:2]] <= bus.mem_data_w;
      end
   end

   assign bus.mem_data_r = mem[bus.mem_addr[7:2]];

   // Reference model: consecutive blocked cycles, beats left in a forced window, cooldown flag
   int          blockedRun;
   int          windowLeft;
   bit          coolPending;
   logic [31:0] refMem [64];
   logic        expRspValid;
   logic [31:0] expRspRdata;
   logic [31:0] expStallCycles;
   logic [31:0] expDmaBeats;

   int checks;
   int errors;
   int obsStall;
   int obsBeats;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic rd, input logic wd,
                                input logic [2:0] op, input logic [31:0] caddr,
                                input logic [31:0] cdata, input logic dv, input logic dwe,
                                input logic [31:0] daddr, input logic [31:0] ddata);
      rst               = r;
      bus.core_rd_en    = rd;
      bus.core_wd_en    = wd;
      bus.core_op_sel   = op;
      bus.core_addr     = caddr;
      bus.core_data_w   = cdata;
      bus.dma_req_valid = dv;
      bus.dma_req_we    = dwe;
      bus.dma_req_addr  = daddr;
      bus.dma_req_wdata = ddata;
   endtask

   // One clock: check outputs at the falling edge, then advance the model on the rising edge
   task automatic checkOutput();
      bit          coreAcc, inWin, expReady, expStall, dmaGo, coreGo;
      logic        expW, expR;
      logic [2:0]  expOp;
      logic [31:0] expAddr, expDw;
      @(negedge clk);
      coreAcc  = bus.core_rd_en | bus.core_wd_en;
      inWin    = windowLeft > 0;
      expReady = 1'b0;
      expStall = 1'b0;
      if (!rst) begin
         if (inWin) begin
            expReady = 1'b1;
            expStall = coreAcc;
         end else if (!coolPending) begin
            expReady = !coreAcc;
         end
      end
      dmaGo  = expReady & bus.dma_req_valid;
      coreGo = !rst & coreAcc & !expStall;
      expW = 1'b0; expR = 1'b0; expOp = 3'b000; expAddr = 32'h0; expDw = 32'h0;
      if (dmaGo) begin
         expW    = bus.dma_req_we;
         expR    = !bus.dma_req_we;
         expOp   = 3'b010;
         expAddr = bus.dma_req_addr & 32'hFFFF_FFFC;
         expDw   = bus.dma_req_wdata;
      end else if (coreGo) begin
         expW    = bus.core_wd_en;
         expR    = bus.core_rd_en;
         expOp   = bus.core_op_sel;
         expAddr = bus.core_addr;
         expDw   = bus.core_data_w;
      end
      obsStall += int'(bus.stallM);
      obsBeats += int'(bus.dma_req_valid & bus.dma_req_ready);
      checkVal("stallM", 32'(bus.stallM), 32'(expStall));
      checkVal("dma_req_ready", 32'(bus.dma_req_ready), 32'(expReady));
      checkVal("mem_w_en", 32'(bus.mem_w_en), 32'(expW));
      checkVal("mem_r_en", 32'(bus.mem_r_en), 32'(expR));
      if (rst || expW || expR) begin
         checkVal("mem_addr", bus.mem_addr, expAddr);
         checkVal("mem_op_sel", 32'(bus.mem_op_sel), 32'(expOp));
      end
      if (rst || expW) checkVal("mem_data_w", bus.mem_data_w, expDw);
      checkVal("dma_rsp_valid", 32'(bus.dma_rsp_valid), 32'(expRspValid));
      if (expRspValid) checkVal("dma_rsp_rdata", bus.dma_rsp_rdata, expRspRdata);
      if (coreGo && bus.core_rd_en) checkVal("core_data_r", bus.core_data_r, refMem[bus.core_addr[7:2]]);
`ifdef DMEM_ARB_STATS_EN
      checkVal("stall_cycles", stallCycles, expStallCycles);
      checkVal("dma_beats", dmaBeats, expDmaBeats);
`endif
      @(posedge clk);
      if (rst) begin
         blockedRun  = 0;
         windowLeft  = 0;
         coolPending = 1'b0;
         expRspValid = 1'b0;
         expRspRdata = 32'h0;
      end else begin
         expRspValid = dmaGo;
         if (dmaGo) expRspRdata = bus.dma_req_we ? 32'h0 : refMem[expAddr[7:2]];
         if (expW) refMem[expAddr[7:2]] = expDw;
         if (inWin) begin
            blockedRun = 0;
            if (!bus.dma_req_valid || windowLeft == 1) begin
               windowLeft  = 0;
               coolPending = 1'b1;
            end else begin
               windowLeft--;
            end
         end else if (coolPending) begin
            coolPending = 1'b0;
         end else if (bus.dma_req_valid && !dmaGo) begin
            blockedRun++;
            if (blockedRun == STARVE_LIMIT) begin
               windowLeft = BURST_MAX;
               blockedRun = 0;
            end
         end else begin
            blockedRun = 0;
         end
      end
`ifdef DMEM_ARB_STATS_EN
      if (rst || statsClr) begin
         expStallCycles = 32'h0;
         expDmaBeats    = 32'h0;
      end else begin
         expStallCycles += 32'(expStall);
         expDmaBeats    += 32'(dmaGo);
      end
`endif
      #1;
   endtask

   // Directed scenarios, then randomized traffic, then the summary
   initial begin
      checks = 0; errors = 0; obsStall = 0; obsBeats = 0;
      blockedRun = 0; windowLeft = 0; coolPending = 1'b0;
      expRspValid = 1'b0; expRspRdata = 32'h0;
      expStallCycles = 32'h0; expDmaBeats = 32'h0;
      for (int i = 0; i < 64; i++) refMem[i] = 32'h0;
`ifdef DMEM_ARB_STATS_EN
      statsClr = 1'b0;
`endif
      memInit = 1'b1;
      applyStimulus(1, 0, 0, 3'b000, 32'h0, 32'h0, 1, 1, 32'h4, 32'h1234);
      checkOutput();
      checkOutput();
      memInit = 1'b0;

      $display("[TB] core-only store/load at 0x10");
      applyStimulus(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0);
      checkOutput();
      applyStimulus(0, 1, 0, 3'b010, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
      @(negedge clk);
      checkVal("core_read_deadbeef", bus.core_data_r, 32'hDEADBEEF);
      checkOutput();

      $display("[TB] DMA into idle core");
      applyStimulus(0, 0, 0, 3'b000, 32'h0, 32'h0, 1, 1, 32'h21, 32'hA5A5A5A5);
      checkOutput();
      checkVal("dma_write_ack_rdata", bus.dma_rsp_rdata, 32'h0);
      applyStimulus(0, 0, 0, 3'b000, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
      checkOutput();
      checkVal("dma_read_back", bus.dma_rsp_rdata, 32'hA5A5A5A5);
      applyStimulus(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
      checkOutput();

      $display("[TB] starvation window");
`ifdef DMEM_ARB_STATS_EN
      statsClr = 1'b1;
      checkOutput();
      statsClr = 1'b0;
`endif
      obsStall = 0; obsBeats = 0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(0, 1, 0, 3'b010, 32'h10, 32'h0, 1, 1, 32'h40 + 32'(i * 4), 32'h100 + 32'(i));
         checkOutput();
      end
      checkVal("starve_stall_count", 32'(obsStall), 32'(BURST_MAX));
      checkVal("starve_beat_count", 32'(obsBeats), 32'(BURST_MAX));
`ifdef DMEM_ARB_STATS_EN
      checkVal("stats_stall_after_window", stallCycles, 32'd4);
      checkVal("stats_beats_after_window", dmaBeats, 32'd4);
      applyStimulus(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
      statsClr = 1'b1;
      checkOutput();
      statsClr = 1'b0;
      checkVal("stats_stall_cleared", stallCycles, 32'd0);
      checkVal("stats_beats_cleared", dmaBeats, 32'd0);
`endif
      applyStimulus(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
      checkOutput();

      $display("[TB] early window exit");
      obsBeats = 0;
      for (int i = 0; i < STARVE_LIMIT + 2; i++) begin
         applyStimulus(0, 1, 0, 3'b010, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
         checkOutput();
      end
      checkVal("early_exit_beats", 32'(obsBeats), 32'd2);
      applyStimulus(0, 1, 0, 3'b010, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
      checkOutput();
      @(negedge clk);
      checkVal("cool_stall_released", 32'(bus.stallM), 32'd0);
      checkOutput();
      checkOutput();

      $display("[TB] reset during a burst");
      for (int i = 0; i < STARVE_LIMIT + 1; i++) begin
         applyStimulus(0, 1, 0, 3'b010, 32'h10, 32'h0, 1, 1, 32'h80, 32'h0BAD0000 + 32'(i));
         checkOutput();
      end
      applyStimulus(1, 1, 0, 3'b010, 32'h10, 32'h0, 1, 1, 32'h84, 32'hCAFEF00D);
      checkOutput();
      applyStimulus(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
      checkOutput();
      checkVal("no_write_in_reset", mem[33], 32'h0);

      $display("[TB] random traffic");
      for (int n = 0; n < 800; n++) begin
         logic r, rd, wd, dv, dwe;
         int   sel;
         r   = ($urandom_range(0, 59) == 0);
         sel = int'($urandom_range(0, 9));
         rd  = (sel < 4);
         wd  = (sel >= 4 && sel < 6);
         dv  = ($urandom_range(0, 9) < 7);
         dwe = $urandom_range(0, 1) == 1;
         applyStimulus(r, rd, wd, 3'($urandom_range(0, 7)), 32'($urandom_range(0, 63)) << 2,
                       $urandom, dv, dwe, 32'($urandom_range(0, 255)), $urandom);
`ifdef DMEM_ARB_STATS_EN
         statsClr = ($urandom_range(0, 99) == 0);
`endif
         checkOutput();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the core MEM stage and a DMA/loader port.
- Sits between the memory stage and the data_memory instance.
- Core has priority. A starvation counter forces a bounded DMA burst window, during which the core is stalled.
- A one-cycle cooldown after each window guarantees core progress.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles a DMA request may wait before it forces ownership (legal range 1..15).
- BURST_MAX, 4: maximum DMA beats per forced window (legal range 1..16).
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- core_rd_en  in  1  MEM-stage load.
- core_wd_en  in  1  MEM-stage store.
- core_op_sel  in  3  func3 of the core access.
- core_addr  in  ADDR_W  core address (ALU result).
- core_data_w  in  32  core store data.
- core_data_r  out  32  read data to the MEM stage; combinational pass-through of mem_data_r.
- stallM  out  1  core access not granted this cycle; the pipeline must hold the MEM stage.
- dma_req_valid  in  1  DMA request valid.
- dma_req_ready  out  1  DMA request accepted this cycle.
- dma_req_we  in  1  1 = write, 0 = read.
- dma_req_addr  in  ADDR_W  DMA word address.
- dma_req_wdata  in  32  DMA write data.
- dma_rsp_valid  out  1  response pulse.
- dma_rsp_rdata  out  32  registered read data; 0 for write acks.
- mem_w_en  out  1  to data_memory.
- mem_r_en  out  1  to data_memory.
- mem_op_sel  out  3  to data_memory.
- mem_addr  out  ADDR_W  to data_memory.
- mem_data_w  out  32  to data_memory.
- mem_data_r  in  32  combinational read data from data_memory.

Behaviour:
- Definitions:
  - core_acc = core_rd_en | core_wd_en.
  - A DMA beat is accepted when dma_req_valid & dma_req_ready.
- States: IDLE, DMA_OWN, COOL.
- Reset: state=IDLE, starve_cnt=0, beat_cnt=0, dma_rsp_valid=0, dma_rsp_rdata=0.
  - While rst=1: stallM=0, dma_req_ready=0, mem_w_en=0, mem_r_en=0, other mem_* outputs 0.
  - Reset mid-burst aborts the window. Any response owed for a beat accepted in the reset cycle is dropped.
- IDLE:
  - Core granted when core_acc=1 (stallM=0).
  - DMA granted (dma_req_ready=1) only when core_acc=0.
  - starve_cnt increments, saturating at STARVE_LIMIT, each cycle dma_req_valid=1 and no beat is accepted. It clears on any accepted beat or when dma_req_valid=0.
  - When starve_cnt==STARVE_LIMIT-1 and the DMA is blocked again, go to DMA_OWN next cycle with beat_cnt=0.
- DMA_OWN:
  - dma_req_ready=1 and stallM=core_acc.
  - Each accepted beat increments beat_cnt.
  - Go to COOL when a beat is accepted with beat_cnt==BURST_MAX-1, or when dma_req_valid=0. No beat is granted in the exit cycle for the valid=0 case.
  - starve_cnt is cleared throughout.
- COOL:
  - Exactly one cycle; then IDLE.
  - dma_req_ready=0, stallM=0; the core is granted if core_acc.
  - starve_cnt does not count in COOL.
- Memory muxing:
  - Core grant: mem_* = core_* signals.
  - DMA grant: mem_w_en=dma_req_we, mem_r_en=~dma_req_we, mem_op_sel=3'b010 (word), mem_addr={dma_req_addr[ADDR_W-1:2],2'b00} (misalignment silently forced aligned), mem_data_w=dma_req_wdata.
  - No grant: w_en=r_en=0.
  - Never both requesters granted in one cycle.
- DMA response:
  - dma_rsp_valid=1 exactly one cycle after each accepted beat.
  - dma_rsp_rdata = mem_data_r captured at acceptance for reads, 0 for writes.
  - No response backpressure. Back-to-back beats give back-to-back responses.
- stallM does not depend on stallM (no combinational loop). It depends only on state and core_acc.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined: adds output ports stall_cycles (32 bits, counts cycles with stallM=1) and dma_beats (32 bits, counts accepted beats).
  - Both wrap at 2^32 and reset to 0.
  - Both also clear on input stats_clr (1 bit, synchronous); when stats_clr coincides with an event, the count reads 0.
- Undefined: the ports and counters are absent. Functional behaviour is otherwise identical.

Test Plan:
- Core-only: core_rd_en=1 at addr 0x10 holding 0xDEADBEEF, no DMA -> core_data_r=0xDEADBEEF same cycle, stallM=0 every cycle.
- DMA into idle core: core_acc=0, DMA write 0xA5A5A5A5 to 0x21 -> mem_addr=0x20, mem_op_sel=3'b010, ready=1 same cycle, rsp_valid next cycle with rdata=0. A following DMA read of 0x20 returns 0xA5A5A5A5.
- Starvation: core_acc held 1, DMA valid held, STARVE_LIMIT=4 -> no grant for 4 cycles, then DMA_OWN. Exactly 4 beats with stallM=1, then COOL with the core granted, then IDLE.
- Early window exit: in DMA_OWN after 2 beats drop dma_req_valid -> COOL next cycle, stallM returns 0, beat count 2.
- Reset mid-burst: assert rst during DMA_OWN beat 2 -> next cycle state IDLE, stallM=0, dma_rsp_valid=0, no memory write in the reset cycle.
- Stats (with DMEM_ARB_STATS_EN): rerun the starvation scenario -> stall_cycles=4, dma_beats=4. Pulse stats_clr -> both 0.
